// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: AES SubBytes over a 128-bit state, LANES S-box lookups per cycle with in-place write-back.
module sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t fsm, fsm_nxt;
  logic [CW-1:0] cnt;
  logic [127:0]  data, data_sub;
  logic          last;
  assign last      = cnt == CW'(N - 1);
  assign out_state = data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  always_comb
    fsm_nxt = (fsm == IDLE) ? (in_valid ? RUN : IDLE) :
              (fsm == RUN)  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = fsm == IDLE;
    out_valid = fsm == DONE;
  end
  // group cnt selects bytes cnt*LANES .. cnt*LANES+LANES-1; all others pass through
  always_comb begin
    data_sub = data;
    for (int j = 0; j < LANES; j++)
      data_sub[127-8*(int'(cnt)*LANES+j) -: 8] = SBOX[data[127-8*(int'(cnt)*LANES+j) -: 8]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (fsm == IDLE && in_valid) begin
      data <= in_state;
      cnt  <= '0;
    end else if (fsm == RUN) begin
      data <= data_sub;
      cnt  <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb_sub_bytes_serial: runs all five LANES variants side by side against a GF(2^8) S-box model.
module tb_sub_bytes_serial;
  localparam int NI = 5;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [127:0] in_state = '0;
  logic [NI-1:0] in_ready, out_valid;
  logic [127:0] out_state [NI];
  int checks = 0, errors = 0, cyc = 0;
  bit b2b = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  // multiplicative inverse by exhaustive search, then the FIPS-197 affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] v = 0;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_ref(s[127-8*k -: 8]);
    return r;
  endfunction
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = 1 << g;
    logic [127:0] q [$];
    int acc_at = 0, last_acc = -1, acc_cnt = 0;
    bit pv = 0;
    sub_bytes_serial #(.LANES(L)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_state(in_state), .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_state(out_state[g])
    );
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        pv = 0;
        last_acc = -1;
      end else begin
        if (out_valid[g] && !pv) begin
          chk($sformatf("latency_l%0d", L), 128'(cyc - acc_at), 128'(16 / L));
          if (q.size() == 0) chk($sformatf("spurious_l%0d", L), 128'(1), 128'(0));
          else chk($sformatf("result_l%0d", L), out_state[g], q.pop_front());
        end
        pv = out_valid[g];
        if (!b2b) last_acc = -1;
        if (in_valid && in_ready[g]) begin
          if (b2b && last_acc >= 0) chk($sformatf("spacing_l%0d", L), 128'(cyc + 1 - last_acc), 128'(16 / L + 2));
          acc_at = cyc + 1;
          last_acc = b2b ? acc_at : -1;
          q.push_back(ref_sub(in_state));
          acc_cnt++;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ov(input int i);
    int n = 0;
    while (!out_valid[i] && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("ov_timeout_%0d", i), 128'(out_valid[i]), 128'(1));
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(&in_ready) && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", 128'(&in_ready), 128'(1));
  endtask
  task automatic send(input logic [127:0] blk);
    int n = 0;
    in_valid = 1;
    in_state = blk;
    tick();
    while (in_ready[2] && n < 40) begin
      tick();
      n++;
    end
    in_valid = 0;
    chk("accept_timeout", 128'(in_ready[2]), 128'(0));
  endtask
  initial begin
    logic [127:0] a, b;
    int a0, base, n;
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(5'h1f));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state[2], 128'(0));
    tick();
    rst_n = 1;
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    wait_ov(2);
    chk("fips_b", out_state[2], 128'hd42711aee0bf98f1b8b45de51e415230);
    out_ready = 1;
    wait_idle();
    out_ready = 0;
    in_valid = 1;
    in_state = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    in_valid = 0;
    for (int i = 0; i < NI; i++) begin
      wait_ov(i);
      chk($sformatf("sweep_%0d", i), out_state[i], 128'h637c777bf26b6fc53001672bfed7ab76);
    end
    out_ready = 1;
    wait_idle();
    out_ready = 0;
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(a);
    wait_ov(2);
    a0 = g_dut[2].acc_cnt;
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      in_state = b;
      tick();
      chk("bp_state", out_state[2], ref_sub(a));
      chk("bp_in_ready", 128'(in_ready[2]), 128'(0));
      chk("bp_out_valid", 128'(out_valid[2]), 128'(1));
    end
    chk("bp_no_capture", 128'(g_dut[2].acc_cnt), 128'(a0));
    in_valid = 1;
    out_ready = 1;
    tick();
    chk("bp_release_ready", 128'(in_ready[2]), 128'(1));
    tick();
    chk("bp_second_accept", 128'(g_dut[2].acc_cnt), 128'(a0 + 1));
    in_valid = 0;
    wait_ov(2);
    wait_idle();
    in_valid = 1;
    in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    in_valid = 0;
    repeat (7) tick();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(5'h1f));
    for (int i = 0; i < NI; i++) chk($sformatf("mid_rst_state_%0d", i), out_state[i], 128'(0));
    tick();
    rst_n = 1;
    in_state = '0;
    in_valid = 1;
    tick();
    in_valid = 0;
    wait_ov(0);
    chk("zero_block", out_state[0], {16{8'h63}});
    wait_idle();
    b2b = 1;
    in_valid = 1;
    base = g_dut[2].acc_cnt;
    n = 0;
    while (g_dut[2].acc_cnt < base + 8 && n < 200) begin
      in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      n++;
    end
    chk("b2b_count", 128'(g_dut[2].acc_cnt - base), 128'(8));
    in_valid = 0;
    b2b = 0;
    wait_idle();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

Serialized AES-128 SubBytes stage that sits directly upstream of the combinational S-box lookup and drives it. It accepts a 128-bit state over a valid/ready handshake and feeds its 16 bytes to `LANES` S-box instances, `LANES` bytes per cycle. It writes each substituted byte back in place and presents the full substituted state downstream over a second valid/ready handshake. `LANES` trades area for latency between the round datapath and the ShiftRows stage.

## Interface
- `LANES`, default 4: number of S-box instances and bytes substituted per cycle.
  - Legal values are 1, 2, 4, 8 and 16.
  - Any other value must fail elaboration.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_state` holds a block to substitute.
- `in_ready` output 1: block can accept input. Equals (fsm == IDLE).
- `in_state` input 128: input state. Byte k = `in_state[127-8k -: 8]`, k = 0..15. Byte 0 is FIPS-197 s0,0.
- `out_valid` output 1: `out_state` holds a finished result.
- `out_ready` input 1: downstream accepts the result.
- `out_state` output 128: substituted state, same byte ordering as `in_state`. Driven directly from the internal data register.

## Operation
- Internal resources:
  - 128-bit data register `data`.
  - Group counter `cnt`, width clog2(16/LANES), minimum 1 bit.
  - FSM with states IDLE, RUN, DONE.
- N = 16/LANES substitution cycles per block.
- Reset values (asynchronous on `rst_n` low):
  - fsm = IDLE, `cnt` = 0, `data` = 0.
  - Resulting outputs: `out_valid` = 0, `out_state` = 0, `in_ready` = 1.
  - All inputs are ignored while `rst_n` is low.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` = 1: `data` <= `in_state`, `cnt` <= 0, go to RUN.
  - Otherwise stay in IDLE; `data` holds its previous result.
- RUN:
  - `in_ready` = 0, `out_valid` = 0.
  - Lane j (0..LANES-1) indexes its S-box with byte (cnt*LANES + j) of `data`.
  - On the edge, each of those bytes is replaced with its S-box output. All other bytes are unchanged.
  - `cnt` increments by 1.
  - When `cnt` == N-1, go to DONE and wrap `cnt` to 0.
- DONE:
  - `out_valid` = 1.
  - `out_state` and `out_valid` are held stable until `out_ready` = 1.
  - On `out_ready` = 1, go to IDLE.
  - `in_valid` is ignored here, because `in_ready` = 0.
- The S-box instances are purely combinational, index to value. No registers between `data` and the S-box, or between the S-box and the `data` write-back.
- In RUN and DONE, `in_valid` and `in_state` have no effect. Upstream must hold its block until it sees `in_ready`.
- `out_ready` has no effect outside DONE.
- Reset asserted in any state (mid-RUN or mid-DONE) aborts the block. The partial result is discarded and all registers return to their reset values.

## Timing
- Accept edge A occurs where `in_valid` && `in_ready`.
- `out_valid` rises on edge A+N:
  - LANES=1: 16 cycles.
  - LANES=4: 4 cycles.
  - LANES=16: 1 cycle.
- Output handshake completes on the first edge in DONE with `out_ready` = 1. `in_ready` rises on that same edge.
- Minimum spacing between accepts is N+2 cycles: one RUN stretch, one DONE cycle, one IDLE cycle.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. Both outputs are decoded from registered FSM state only.
- Critical path: `data` byte mux (select = `cnt`) -> S-box -> `data` write-enable mux.

## Test plan
- FIPS-197 App. B round 1 (LANES=4):
  - Stimulus: `in_state` = 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: `out_state` = d42711aee0bf98f1b8b45de51e415230, with `out_valid` rising exactly 4 cycles after the accept edge.
- LANES sweep (1, 2, 4, 8, 16):
  - Stimulus: `in_state` = 000102030405060708090a0b0c0d0e0f.
  - Required: `out_state` = 637c777bf26b6fc53001672bfed7ab76.
  - Required latency: 16/8/4/2/1 cycles respectively.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 6 cycles in DONE while toggling `in_valid` with a different `in_state`.
  - Required: `out_state` stable; `in_ready` stays 0; the second block is not captured.
  - Release `out_ready`: `in_ready` = 1 on the next cycle, and the second block is then accepted.
- Reset mid-RUN:
  - Stimulus: LANES=1, assert `rst_n` = 0 asynchronously 7 cycles after accept.
  - Required: `out_valid` = 0, `out_state` = 0 and `in_ready` = 1 immediately, with no result produced.
  - Then an all-zero input yields 63636363636363636363636363636363.
- Back-to-back:
  - Stimulus: 8 random blocks with `in_valid` and `out_ready` held at 1.
  - Required: every result matches a reference S-box model; accepts are spaced exactly N+2 cycles.
